// File: rtl/md_unit.sv
// Multiply/divide unit: results computed at issue, committed to HI/LO after a busy window.
// Optional MADD (op 7) is enabled by defining MDU_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_nx;
  logic [3:0]  r_count, w_count_nx;
  logic [31:0] r_hi, r_lo, r_shi, r_slo;
  logic [31:0] w_hi_nx, w_lo_nx, w_shi_nx, w_slo_nx;

  logic w_is_mul, w_is_div, w_is_madd, w_is_mthi, w_is_mtlo;
  assign w_is_mul  = (E_md_op == 3'd1) || (E_md_op == 3'd2);
  assign w_is_div  = (E_md_op == 3'd3) || (E_md_op == 3'd4);
  assign w_is_mthi = (E_md_op == 3'd5);
  assign w_is_mtlo = (E_md_op == 3'd6);
`ifdef MDU_MADD_EN
  assign w_is_madd = (E_md_op == 3'd7);
`else
  assign w_is_madd = 1'b0;
`endif

  logic signed [31:0] w_a_s, w_b_s, w_bd_s;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  assign w_a_s    = E_rs_data;
  assign w_b_s    = E_rt_data;
  assign w_prod_s = w_a_s * w_b_s;
  assign w_prod_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};

  // Degenerate divides take a fixed result; divisor is forced to 1 so the divider stays defined.
  logic        w_dz, w_ovf;
  logic [31:0] w_bd_u;
  logic signed [31:0] w_q_s, w_r_s;
  logic [31:0] w_q_u, w_r_u;
  assign w_dz   = (E_rt_data == 32'd0);
  assign w_ovf  = (E_rs_data == 32'h8000_0000) && (E_rt_data == 32'hFFFF_FFFF);
  assign w_bd_s = (w_dz || w_ovf) ? 32'sd1 : w_b_s;
  assign w_bd_u = w_dz ? 32'd1 : E_rt_data;
  assign w_q_s  = w_a_s / w_bd_s;
  assign w_r_s  = w_a_s % w_bd_s;
  assign w_q_u  = E_rs_data / w_bd_u;
  assign w_r_u  = E_rs_data % w_bd_u;

  logic [63:0] w_res;
  always_comb begin
    w_res = 64'd0;
    unique case (1'b1)
      (E_md_op == 3'd1): w_res = w_prod_s;
      (E_md_op == 3'd2): w_res = w_prod_u;
      (E_md_op == 3'd3): begin
        if (w_dz)       w_res = {E_rs_data, 32'hFFFF_FFFF};
        else if (w_ovf) w_res = {32'd0, 32'h8000_0000};
        else            w_res = {w_r_s, w_q_s};
      end
      (E_md_op == 3'd4): begin
        if (w_dz) w_res = {E_rs_data, 32'hFFFF_FFFF};
        else      w_res = {w_r_u, w_q_u};
      end
`ifdef MDU_MADD_EN
      (E_md_op == 3'd7): w_res = {r_hi, r_lo} + w_prod_s;
`endif
      default: w_res = 64'd0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_shi_nx   = r_shi;
    w_slo_nx   = r_slo;
    unique case (r_state)
      S_IDLE: begin
        if (E_start) begin
          unique case (1'b1)
            (w_is_mul || w_is_madd): begin
              {w_shi_nx, w_slo_nx} = w_res;
              w_count_nx = 4'(MULT_CYCLES);
              w_state_nx = S_BUSY;
            end
            w_is_div: begin
              {w_shi_nx, w_slo_nx} = w_res;
              w_count_nx = 4'(DIV_CYCLES);
              w_state_nx = S_BUSY;
            end
            w_is_mthi: w_hi_nx = E_rs_data;
            w_is_mtlo: w_lo_nx = E_rs_data;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        w_count_nx = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_hi_nx    = r_shi;
          w_lo_nx    = r_slo;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_shi   <= 32'd0;
      r_slo   <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_shi   <= w_shi_nx;
      r_slo   <= w_slo_nx;
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state == S_BUSY);
  assign md_stall = D_is_md &&
    (busy || (E_start && (w_is_mul || w_is_div || w_is_madd)));

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Expected values are hand-computed; MADD expectations follow MDU_MADD_EN.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        E_start = 1'b0;
  logic [2:0]  E_md_op = 3'd0;
  logic [31:0] E_rs_data = 32'd0;
  logic [31:0] E_rt_data = 32'd0;
  logic        D_is_md = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, md_stall;

  int nvec = 0;
  int nmis = 0;

  md_unit dut (
    .clk(clk), .reset(reset),
    .E_start(E_start), .E_md_op(E_md_op),
    .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .D_is_md(D_is_md),
    .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && E_start && busy) begin
      nmis++;
      $display("FAIL protocol: E_start while busy");
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    E_start = 1'b1; E_md_op = op; E_rs_data = a; E_rt_data = b;
    tick();
    E_start = 1'b0; E_md_op = 3'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    nvec++; if (hi !== 32'd0) begin nmis++; $display("FAIL reset_hi: got %h want 0", hi); end
    nvec++; if (lo !== 32'd0) begin nmis++; $display("FAIL reset_lo: got %h want 0", lo); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (md_stall !== 1'b0) begin nmis++; $display("FAIL reset_stall: got %b want 0", md_stall); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult;
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 5; i++) begin
      nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
      nvec++; if (md_stall !== 1'b0) begin nmis++; $display("FAIL mult_nostall[%0d]: got %b want 0", i, md_stall); end
      nvec++; if (lo !== 32'd0) begin nmis++; $display("FAIL mult_early[%0d]: lo got %h want 0", i, lo); end
      tick();
    end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL mult_done: busy got %b want 0", busy); end
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nmis++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFF_FFFE) begin nmis++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_multu;
    int cnt;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    cnt = 0;
    while (busy && cnt < 20) begin cnt++; tick(); end
    nvec++; if (cnt !== 5) begin nmis++; $display("FAIL multu_cycles: got %0d want 5", cnt); end
    nvec++; if (hi !== 32'd1) begin nmis++; $display("FAIL multu_hi: got %h want 1", hi); end
    nvec++; if (lo !== 32'hFFFF_FFFE) begin nmis++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div;
    logic [2:0]  ops [5] = '{3'd3, 3'd4, 3'd3, 3'd3, 3'd4};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFB, 32'h8000_0000, 32'd100};
    logic [31:0] bs  [5] = '{32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFB, 32'd0, 32'd2};
    logic [31:0] elo [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14};
    int cnt;
    for (int k = 0; k < 5; k++) begin
      issue(ops[k], as[k], bs[k]);
      cnt = 0;
      while (busy && cnt < 20) begin cnt++; tick(); end
      nvec++; if (cnt !== 10) begin nmis++; $display("FAIL div%0d_cycles: got %0d want 10", k, cnt); end
      nvec++; if (hi !== ehi[k]) begin nmis++; $display("FAIL div%0d_hi: got %h want %h", k, hi, ehi[k]); end
      nvec++; if (lo !== elo[k]) begin nmis++; $display("FAIL div%0d_lo: got %h want %h", k, lo, elo[k]); end
    end
  endtask

  task automatic test_stall;
    D_is_md = 1'b1;
    E_start = 1'b1; E_md_op = 3'd1; E_rs_data = 32'd3; E_rt_data = 32'd5;
    #1;
    nvec++; if (md_stall !== 1'b1) begin nmis++; $display("FAIL stall_issue: got %b want 1", md_stall); end
    tick();
    E_start = 1'b0; E_md_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      nvec++; if (md_stall !== 1'b1) begin nmis++; $display("FAIL stall_busy[%0d]: got %b want 1", i, md_stall); end
      tick();
    end
    nvec++; if (md_stall !== 1'b0) begin nmis++; $display("FAIL stall_release: got %b want 0", md_stall); end
    nvec++; if (lo !== 32'd15) begin nmis++; $display("FAIL stall_lo: got %h want f", lo); end
    D_is_md = 1'b0;
  endtask

  task automatic test_reset_abort;
    issue(3'd4, 32'd100, 32'd7);
    tick(); tick(); tick();
    nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL abort_pre: busy got %b want 1", busy); end
    reset = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL abort_busy: got %b want 0", busy); end
    nvec++; if (hi !== 32'd0 || lo !== 32'd0) begin nmis++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi, lo); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    nvec++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      nmis++; $display("FAIL abort_late: got %h/%h busy %b want 0/0 busy 0", hi, lo, busy);
    end
  endtask

  task automatic test_madd;
    int cnt;
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'd10, 32'd0);
    nvec++; if (hi !== 32'd0 || lo !== 32'd10) begin nmis++; $display("FAIL mt_hilo: got %h/%h want 0/a", hi, lo); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL mt_busy: got %b want 0", busy); end
    D_is_md = 1'b1;
    E_start = 1'b1; E_md_op = 3'd7; E_rs_data = 32'd3; E_rt_data = 32'd4;
    #1;
`ifdef MDU_MADD_EN
    nvec++; if (md_stall !== 1'b1) begin nmis++; $display("FAIL madd_stall: got %b want 1", md_stall); end
`else
    nvec++; if (md_stall !== 1'b0) begin nmis++; $display("FAIL madd_stall: got %b want 0", md_stall); end
`endif
    tick();
    E_start = 1'b0; E_md_op = 3'd0; D_is_md = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin cnt++; tick(); end
    for (int i = 0; i < 3; i++) tick();
`ifdef MDU_MADD_EN
    nvec++; if (cnt !== 5) begin nmis++; $display("FAIL madd_cycles: got %0d want 5", cnt); end
    nvec++; if (hi !== 32'd0 || lo !== 32'd22) begin nmis++; $display("FAIL madd_hilo: got %h/%h want 0/16", hi, lo); end
`else
    nvec++; if (cnt !== 0) begin nmis++; $display("FAIL madd_cycles: got %0d want 0", cnt); end
    nvec++; if (hi !== 32'd0 || lo !== 32'd10) begin nmis++; $display("FAIL madd_hilo: got %h/%h want 0/a", hi, lo); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_reset_abort();
    test_stall();
    test_madd();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
